id_ex_stage: RTL

ID/EX pipeline stage of the RISC-V core: registers the decode-stage control bundle from the control unit together with operands, immediate, register indices and PC into the execute stage. Contains load-use hazard detection that stalls IF/ID and inserts a bubble, and handles branch flush and downstream hold. Sits between the control unit/register file (decode) and the ALU/forwarding logic (execute).

---
 rtl/riscv_pkg.sv | 75 +++++++
 rtl/load_use_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode/execute definitions: opcodes, ALUOp encodings,
// the control bundle carried from decode into execute, and the ID/EX
// register layout used by id_ex_stage.
package riscv_pkg;

  localparam int XLEN = 32;

  // Major opcodes the pipeline needs to recognise.
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // ALUOp encodings produced by the control unit.
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_bundle_t;

  // A bubble can neither write the register file nor touch memory.
  localparam ctrl_bundle_t CTRL_BUBBLE = '{
    branch:   1'b0,
    memread:  1'b0,
    memtoreg: 1'b0,
    memwrite: 1'b0,
    alusrc:   1'b0,
    regwrite: 1'b0,
    aluop:    ALUOP_LDST
  };

  // Everything the ID/EX register carries into execute.
  typedef struct packed {
    logic             valid;
    ctrl_bundle_t     ctrl;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [3:0]       funct;
  } ex_regs_t;

  // Bubbles also clear the data fields so a squashed slot is easy to spot
  // on a waveform and never leaks stale operands into forwarding.
  localparam ex_regs_t EX_BUBBLE = '{
    valid:    1'b0,
    ctrl:     CTRL_BUBBLE,
    pc:       '0,
    rs1_data: '0,
    rs2_data: '0,
    imm:      '0,
    rs1:      '0,
    rs2:      '0,
    rd:       '0,
    funct:    '0
  };

  // Only R-type, store and branch actually read rs2; for every other
  // format the rs2 field is immediate bits and must not raise a hazard.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: a load sitting in EX whose
// destination is read by the instruction currently in decode.
// Only instantiated when HAZARD_DETECT_EN is defined.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  // x0 is hard-wired zero, so a load into x0 never produces a value to wait for.
  assign ex_is_load = ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0);
  assign rs1_match  = (ex_rd_i == id_rs1_i);
  assign rs2_match  = uses_rs2(id_opcode_i) & (ex_rd_i == id_rs2_i);

  assign hazard_o = ex_is_load & id_valid_i & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and
// downstream hold.
// Configuration macro: HAZARD_DETECT_EN enables load-use detection; when
// undefined the hazard term is tied off and stall_o follows hold_i alone.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,

  input  logic            id_valid_i,
  input  logic [6:0]      id_opcode_i,
  input  logic            id_branch_i,
  input  logic            id_memread_i,
  input  logic            id_memtoreg_i,
  input  logic            id_memwrite_i,
  input  logic            id_alusrc_i,
  input  logic            id_regwrite_i,
  input  logic [1:0]      id_aluop_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic [3:0]      id_funct_i,

  input  logic            flush_i,
  input  logic            hold_i,
  output logic            stall_o,

  output logic            ex_valid_o,
  output logic            ex_branch_o,
  output logic            ex_memread_o,
  output logic            ex_memtoreg_o,
  output logic            ex_memwrite_o,
  output logic            ex_alusrc_o,
  output logic            ex_regwrite_o,
  output logic [1:0]      ex_aluop_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [3:0]      ex_funct_o
);

  ex_regs_t ex_q;
  ex_regs_t ex_d;
  ex_regs_t id_slot;
  logic     hazard;

  // Gather the decode-side bundle into the register layout.
  always_comb begin
    id_slot               = EX_BUBBLE;
    id_slot.valid         = 1'b1;
    id_slot.ctrl.branch   = id_branch_i;
    id_slot.ctrl.memread  = id_memread_i;
    id_slot.ctrl.memtoreg = id_memtoreg_i;
    id_slot.ctrl.memwrite = id_memwrite_i;
    id_slot.ctrl.alusrc   = id_alusrc_i;
    id_slot.ctrl.regwrite = id_regwrite_i;
    id_slot.ctrl.aluop    = id_aluop_i;
    id_slot.pc            = id_pc_i;
    id_slot.rs1_data      = id_rs1_data_i;
    id_slot.rs2_data      = id_rs2_data_i;
    id_slot.imm           = id_imm_i;
    id_slot.rs1           = id_rs1_i;
    id_slot.rs2           = id_rs2_i;
    id_slot.rd            = id_rd_i;
    id_slot.funct         = id_funct_i;
  end

`ifdef HAZARD_DETECT_EN
  load_use_detect u_load_use_detect (
    .ex_valid_i   (ex_q.valid),
    .ex_memread_i (ex_q.ctrl.memread),
    .ex_rd_i      (ex_q.rd),
    .id_valid_i   (id_valid_i),
    .id_opcode_i  (id_opcode_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .hazard_o     (hazard)
  );
`else
  // Software guarantees no load-use pairs; the opcode is then only needed
  // for hazard detection and is deliberately left unused.
  logic unused_opcode;
  assign unused_opcode = ^id_opcode_i;
  assign hazard        = 1'b0;
`endif

  // Upstream freezes for a hold or a load-use; flush never feeds this path,
  // the flush owner overrides the stall on its own side.
  assign stall_o = hold_i | hazard;

  // Next EX contents in priority order: flush, hold, bubble, normal load.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = EX_BUBBLE;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (hazard || !id_valid_i) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d = id_slot;
    end
  end

  // EX register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_branch_o   = ex_q.ctrl.branch;
  assign ex_memread_o  = ex_q.ctrl.memread;
  assign ex_memtoreg_o = ex_q.ctrl.memtoreg;
  assign ex_memwrite_o = ex_q.ctrl.memwrite;
  assign ex_alusrc_o   = ex_q.ctrl.alusrc;
  assign ex_regwrite_o = ex_q.ctrl.regwrite;
  assign ex_aluop_o    = ex_q.ctrl.aluop;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_data_o = ex_q.rs1_data;
  assign ex_rs2_data_o = ex_q.rs2_data;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_funct_o    = ex_q.funct;

endmodule
